// File: rtl/fp_mult_pkg.sv
// Shared types and field-width helpers for the multiplier round/pack stage.
package fp_mult_pkg;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rnd_mode_t;

  localparam int SIG_WIDTH = 23;
  localparam int EX_WIDTH  = 8;

  // Largest biased exponent field value; it encodes infinity/NaN.
  function automatic int exp_max(input int ew);
    return (1 << ew) - 1;
  endfunction

  function automatic int result_width(input int sw, input int ew);
    return sw + ew + 1;
  endfunction

endpackage

// File: rtl/round_pack_mult_decide.sv
// Rounding decision: whether to increment the truncated fraction.
module round_decide
  import fp_mult_pkg::*;
(
  input  rnd_mode_t mode,
  input  logic      sign,
  input  logic      lsb,
  input  logic      guard,
  input  logic      sticky,
  output logic      round_up
);

  always_comb begin
    round_up = 1'b0;
    case (mode)
      RNE:     round_up = guard & (sticky | lsb);
      RTZ:     round_up = 1'b0;
      RUP:     round_up = (guard | sticky) & ~sign;
      RDN:     round_up = (guard | sticky) & sign;
      default: round_up = 1'b0;
    endcase
  end

endmodule

// File: rtl/round_pack_mult_hca.sv
// Han-Carlson parallel-prefix adder: odd bits get a Kogge-Stone tree, even bits one extra level.
module hca_adder #(
  parameter int width = 24
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] sum
);

  localparam int NL = (width > 1) ? $clog2(width) : 1;

  logic carry [0:width-1];
  genvar gi, lv;

  generate
    for (lv = 0; lv <= NL; lv++) begin : g_level
      logic [width-1:0] g;
      logic [width-1:0] p;
      for (gi = 0; gi < width; gi++) begin : g_node
        localparam int DIST = (lv > 0) ? (1 << (lv - 1)) : 0;
        if (lv == 0) begin : g_init
          // Carry-in is folded into bit 0 so the prefix tree needs no extra column.
          if (gi == 0) begin : g_cin
            assign g[gi] = (a[gi] & b[gi]) | ((a[gi] ^ b[gi]) & cin);
          end else begin : g_raw
            assign g[gi] = a[gi] & b[gi];
          end
          assign p[gi] = a[gi] ^ b[gi];
        end else if ((gi % 2 == 1) && (gi >= DIST)) begin : g_comb
          assign g[gi] = g_level[lv-1].g[gi] | (g_level[lv-1].p[gi] & g_level[lv-1].g[gi-DIST]);
          assign p[gi] = g_level[lv-1].p[gi] & g_level[lv-1].p[gi-DIST];
        end else begin : g_pass
          assign g[gi] = g_level[lv-1].g[gi];
          assign p[gi] = g_level[lv-1].p[gi];
        end
      end
    end

    assign carry[0] = cin;
    for (gi = 1; gi < width; gi++) begin : g_carry
      if (((gi - 1) % 2 == 1) || (gi == 1)) begin : g_odd
        assign carry[gi] = g_level[NL].g[gi-1];
      end else begin : g_even
        assign carry[gi] = g_level[NL].g[gi-1] | (g_level[NL].p[gi-1] & g_level[NL].g[gi-2]);
      end
    end

    for (gi = 0; gi < width; gi++) begin : g_sum
      assign sum[gi] = g_level[0].p[gi] ^ carry[gi];
    end
  endgenerate

  // Top-level group propagates and final carry-out are not needed by the sum.
  logic unused_prefix;
  assign unused_prefix = ^{g_level[NL].p, g_level[NL].g[width-1]};

endmodule

// File: rtl/round_pack_mult.sv
// Two-stage round + range-check + IEEE-754 pack with valid/ready handshake.
// Optional directed rounding modes when ROUND_MODE_EN is defined.
module round_pack_mult
  import fp_mult_pkg::*;
#(
  parameter int sig_width = SIG_WIDTH,
  parameter int ex_width  = EX_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               sign,
  input  logic [sig_width-1:0]               mant_norm,
  input  logic                               guard_bit,
  input  logic                               sticky_bit,
  input  logic [ex_width+1:0]                exp_norm,
`ifdef ROUND_MODE_EN
  input  logic [1:0]                         rnd_mode,
`endif
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [result_width(sig_width, ex_width)-1:0] result,
  output logic                               overflow,
  output logic                               underflow,
  output logic                               inexact
);

  localparam int EW2     = ex_width + 2;
  localparam int RW      = result_width(sig_width, ex_width);
  localparam int EXP_MAX = exp_max(ex_width);

  logic                 s1_valid_reg, s1_sign_reg, s1_inexact_reg;
  logic [sig_width-1:0] s1_frac_reg;
  logic [EW2-1:0]       s1_exp_reg;
  logic                 s2_valid_reg;
  logic [RW-1:0]        result_reg, result_next;
  logic                 overflow_reg, underflow_reg, inexact_reg;
  logic                 overflow_next, underflow_next, inexact_next;

  logic s2_adv, s1_adv, accept;
  assign s2_adv   = ~s2_valid_reg | out_ready;
  assign s1_adv   = ~s1_valid_reg | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & in_ready;

  rnd_mode_t mode_in;
`ifdef ROUND_MODE_EN
  assign mode_in = rnd_mode_t'(rnd_mode);
`else
  assign mode_in = RNE;
`endif

  logic               round_up;
  logic [sig_width:0] mant_r;
  logic               carry_out;

  round_decide u_decide (
    .mode     (mode_in),
    .sign     (sign),
    .lsb      (mant_norm[0]),
    .guard    (guard_bit),
    .sticky   (sticky_bit),
    .round_up (round_up)
  );

  hca_adder #(.width(sig_width + 1)) u_inc (
    .a   ({1'b0, mant_norm}),
    .b   ('0),
    .cin (round_up),
    .sum (mant_r)
  );

  assign carry_out = mant_r[sig_width];

`ifdef ROUND_MODE_EN
  rnd_mode_t s1_mode_reg;
  logic      saturate;
  // Modes that round toward zero for this sign clamp to max finite instead of infinity.
  assign saturate = (s1_mode_reg == RTZ) | ((s1_mode_reg == RUP) & s1_sign_reg)
                  | ((s1_mode_reg == RDN) & ~s1_sign_reg);
`endif

  logic exp_nonpos, exp_ovf;
  assign exp_nonpos = s1_exp_reg[EW2-1] | (s1_exp_reg == '0);
  assign exp_ovf    = ~s1_exp_reg[EW2-1] & (s1_exp_reg >= EW2'(EXP_MAX));

  always_comb begin
    result_next    = {s1_sign_reg, s1_exp_reg[ex_width-1:0], s1_frac_reg};
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    inexact_next   = s1_inexact_reg;
    if (exp_nonpos) begin
      result_next    = {s1_sign_reg, {(RW-1){1'b0}}};
      underflow_next = 1'b1;
      inexact_next   = 1'b1;
    end else if (exp_ovf) begin
      result_next   = {s1_sign_reg, {ex_width{1'b1}}, {sig_width{1'b0}}};
      overflow_next = 1'b1;
      inexact_next  = 1'b1;
`ifdef ROUND_MODE_EN
      if (saturate) begin
        result_next = {s1_sign_reg, {(ex_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_inexact_reg <= 1'b0;
      s1_frac_reg    <= '0;
      s1_exp_reg     <= '0;
`ifdef ROUND_MODE_EN
      s1_mode_reg    <= RNE;
`endif
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (accept) begin
        s1_sign_reg    <= sign;
        s1_inexact_reg <= guard_bit | sticky_bit;
        s1_frac_reg    <= carry_out ? '0 : mant_r[sig_width-1:0];
        s1_exp_reg     <= exp_norm + EW2'(carry_out);
`ifdef ROUND_MODE_EN
        s1_mode_reg    <= mode_in;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      inexact_reg   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg    <= result_next;
        overflow_reg  <= overflow_next;
        underflow_reg <= underflow_next;
        inexact_reg   <= inexact_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign result    = result_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  assign inexact   = inexact_reg;

endmodule

// File: tb/tb_round_pack_mult.sv
// Directed bench for round_pack_mult (binary32 configuration).
module tb_round_pack_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        sign, guard_bit, sticky_bit;
  logic [22:0] mant_norm;
  logic [9:0]  exp_norm;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow, inexact;
`ifdef ROUND_MODE_EN
  logic [1:0]  rnd_mode;
`endif

  int total = 0;
  int bad   = 0;

  round_pack_mult #(.sig_width(23), .ex_width(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign       (sign),
    .mant_norm  (mant_norm),
    .guard_bit  (guard_bit),
    .sticky_bit (sticky_bit),
    .exp_norm   (exp_norm),
`ifdef ROUND_MODE_EN
    .rnd_mode   (rnd_mode),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .overflow   (overflow),
    .underflow  (underflow),
    .inexact    (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [22:0] m, input logic g,
                       input logic st, input logic [9:0] e);
    in_valid   = 1'b1;
    sign       = s;
    mant_norm  = m;
    guard_bit  = g;
    sticky_bit = st;
    exp_norm   = e;
  endtask

  // One isolated transaction: accept, check latency, check packed result and flags.
  task automatic single(input string tag, input logic s, input logic [22:0] m,
                        input logic g, input logic st, input logic [9:0] e,
                        input logic [31:0] want_res, input logic ov,
                        input logic uf, input logic inx);
    out_ready = 1'b1;
    drive(s, m, g, st, e);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid_early"}, {31'b0, out_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_result"}, result, want_res);
    chk({tag, "_flags"}, {29'b0, overflow, underflow, inexact}, {29'b0, ov, uf, inx});
    $display("txn %s: mant=%h g=%b s=%b exp=%h -> result=%h ov=%b uf=%b inx=%b",
             tag, m, g, st, e, result, overflow, underflow, inexact);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    sign = 1'b0; mant_norm = '0; guard_bit = 1'b0; sticky_bit = 1'b0; exp_norm = '0;
`ifdef ROUND_MODE_EN
    rnd_mode = 2'd0;
`endif
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'b0, overflow, underflow, inexact}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();

    single("carry_round", 1'b0, 23'h7FFFFF, 1'b1, 1'b0, 10'd127, 32'h40000000, 1'b0, 1'b0, 1'b1);
    single("tie_even",    1'b0, 23'h000000, 1'b1, 1'b0, 10'd127, 32'h3F800000, 1'b0, 1'b0, 1'b1);
    single("tie_odd",     1'b0, 23'h000001, 1'b1, 1'b0, 10'd127, 32'h3F800002, 1'b0, 1'b0, 1'b1);
    single("below_half",  1'b0, 23'h7FFFFF, 1'b0, 1'b1, 10'd127, 32'h3FFFFFFF, 1'b0, 1'b0, 1'b1);
    single("exact_neg",   1'b1, 23'h123456, 1'b0, 1'b0, 10'd130, 32'hC1123456, 1'b0, 1'b0, 1'b0);
    single("ovf_round",   1'b0, 23'h7FFFFF, 1'b1, 1'b1, 10'd254, 32'h7F800000, 1'b1, 1'b0, 1'b1);
`ifdef ROUND_MODE_EN
    rnd_mode = 2'd1;
    single("ovf_rtz",     1'b0, 23'h7FFFFF, 1'b1, 1'b1, 10'd254, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b1);
    rnd_mode = 2'd0;
`endif
    single("max_finite",  1'b0, 23'h7FFFFF, 1'b0, 1'b0, 10'd254, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0);
    single("exp_255",     1'b1, 23'h000000, 1'b0, 1'b0, 10'd255, 32'hFF800000, 1'b1, 1'b0, 1'b1);
    single("uf_neg",      1'b1, 23'h2AAAAA, 1'b1, 1'b1, 10'h3FE, 32'h80000000, 1'b0, 1'b1, 1'b1);
    single("uf_zero",     1'b1, 23'h000000, 1'b0, 1'b0, 10'd0,   32'h80000000, 1'b0, 1'b1, 1'b1);
    single("min_normal",  1'b0, 23'h000000, 1'b0, 1'b0, 10'd1,   32'h00800000, 1'b0, 1'b0, 1'b0);
    single("round_to_min",1'b0, 23'h7FFFFF, 1'b1, 1'b1, 10'd0,   32'h00800000, 1'b0, 1'b0, 1'b1);

    // Drain, then backpressure with four back-to-back items.
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(1'b0, 23'd1, 1'b0, 1'b0, 10'd127);
    chk("bp_ready_a", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 23'd2, 1'b0, 1'b0, 10'd127);
    chk("bp_ready_b", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 23'd3, 1'b0, 1'b0, 10'd127);
    chk("bp_stall_1", {31'b0, in_ready}, 32'd0);
    chk("bp_valid_1", {31'b0, out_valid}, 32'd1);
    chk("bp_hold_1", result, 32'h3F800001);
    tick();
    chk("bp_stall_2", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_2", result, 32'h3F800001);
    chk("bp_flags_2", {29'b0, overflow, underflow, inexact}, 32'd0);
    tick();
    chk("bp_stall_3", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_3", result, 32'h3F800001);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    $display("txn bp: item 1 held during stall, result=%h", result);
    tick();
    chk("bp_out_b", result, 32'h3F800002);
    chk("bp_out_b_valid", {31'b0, out_valid}, 32'd1);
    $display("txn bp: item 2 result=%h", result);
    drive(1'b0, 23'd4, 1'b0, 1'b0, 10'd127);
    tick();
    in_valid = 1'b0;
    chk("bp_out_c", result, 32'h3F800003);
    $display("txn bp: item 3 result=%h", result);
    tick();
    chk("bp_out_d", result, 32'h3F800004);
    chk("bp_out_d_valid", {31'b0, out_valid}, 32'd1);
    $display("txn bp: item 4 result=%h", result);
    tick();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset with both stages occupied.
    out_ready = 1'b0;
    drive(1'b0, 23'd5, 1'b0, 1'b0, 10'd127);
    tick();
    drive(1'b0, 23'd6, 1'b0, 1'b0, 10'd127);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("pre_rst_result", result, 32'h3F800005);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_result", result, 32'h0);
    chk("async_rst_ready", {31'b0, in_ready}, 32'd1);
    $display("txn async_rst: out_valid=%b result=%h", out_valid, result);
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
    single("post_rst", 1'b1, 23'h400000, 1'b0, 1'b0, 10'd128, 32'hC0400000, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_pack_mult.md
Name: round_pack_mult

Overview:
- Consumer end of the multiplier normalize interface: accepts normalized mantissa, guard/sticky bits, extended exponent and sign.
- Performs rounding, exponent range checking and IEEE-754 packing.
- Two-stage registered pipeline with valid/ready handshake; sits between the normalize stage and the multiplier result port.

Parameters:
sig_width, 23, stored fraction width (without hidden bit)
ex_width, 8, stored exponent width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream data valid
in_ready  out  1  block can accept input this cycle
sign  in  1  product sign
mant_norm  in  sig_width  normalized fraction, hidden bit stripped
guard_bit  in  1  first bit below fraction LSB
sticky_bit  in  1  OR of all lower bits
exp_norm  in  ex_width+2  biased exponent, two's complement (MSB set = negative)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  sig_width+ex_width+1  packed {sign, exponent, fraction}
overflow  out  1  result overflowed to infinity
underflow  out  1  result flushed to zero
inexact  out  1  precision lost

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, result=0, overflow=underflow=inexact=0. Reset mid-operation discards all in-flight data.
- Handshake:
  - s2 advances when ~s2_valid | out_ready.
  - s1 advances when ~s1_valid | s2 advances.
  - in_ready = ~s1_valid | s2 advances (combinational).
  - Transfer occurs when in_valid & in_ready.
  - Latency is 2 cycles from accept to out_valid; full throughput of 1 item per cycle.
  - While out_valid & ~out_ready, result and flags are held stable.
  - Ordering is strictly in order; no drops, no duplicates.
- Stage 1 (round), default RNE:
  - round_up = guard & (sticky | mant_norm[0]).
  - mant_r = {1'b0, mant_norm} + round_up, width sig_width+1. The increment uses the codebase HCA adder with width sig_width+1.
  - If carry out (mant_r[sig_width]=1): fraction = 0 and exp_r = exp_norm + 1; otherwise exp_r = exp_norm.
  - inexact_r = guard | sticky.
  - Register sign, fraction, exp_r (ex_width+2 bits) and inexact_r.
- Stage 2 (range/pack):
  - exp_r negative or zero: result = {sign, 0...}; underflow=1; inexact=1. Flush to zero; no subnormals.
  - exp_r >= 2^ex_width-1: result = {sign, all-ones exponent, zero fraction} (infinity); overflow=1; inexact=1.
  - Otherwise: result = {sign, exp_r[ex_width-1:0], fraction}; inexact = inexact_r.
  - Flags are mutually exclusive between overflow and underflow.
- Simultaneous in_valid and out_ready with both stages full: pipeline shifts and accepts in the same cycle.

Optional Feature:
ROUND_MODE_EN:
- Defined: adds input port rnd_mode[1:0]. Encoding: 0=RNE, 1=RTZ (round_up=0), 2=RUP (round_up=(guard|sticky)&~sign), 3=RDN (round_up=(guard|sticky)&sign). rnd_mode is sampled with the input transfer.
- Overflow result under a directed rounding mode that rounds away from infinity is max finite magnitude: exponent 2^ex_width-2, fraction all ones, overflow=1.
- Undefined: no port; RNE only; overflow always produces infinity.

Decomposition:
- Package fp_mult_pkg:
  - rnd_mode_t enum {RNE, RTZ, RUP, RDN}
  - EXP_MAX = 2^ex_width-1 (localparam function of ex_width)
  - field-width localparams for packing
- Sub-module round_decide: combinational; inputs mode, sign, lsb, guard, sticky; output round_up. The mantissa increment reuses the existing HCA.

Test Plan (sig_width=23, ex_width=8, RNE):
1. mant=0x7FFFFF, guard=1, sticky=0, exp=127, sign=0 -> result 0x40000000, inexact=1, overflow=underflow=0, out_valid 2 cycles after accept.
2. mant=0x000000, guard=1, sticky=0, exp=127 (tie, even LSB) -> result 0x3F800000, inexact=1.
3. mant=0x7FFFFF, guard=1, sticky=1, exp=254 -> result 0x7F800000, overflow=1, inexact=1. With ROUND_MODE_EN and rnd_mode=RTZ -> 0x7F7FFFFF, overflow=1.
4. sign=1, exp=10'h3FE (-2), any mantissa -> result 0x80000000, underflow=1, inexact=1. exp=0 -> same.
5. Back-to-back 4 items, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted; result/flags held stable; all 4 emerge in order once out_ready=1.
6. rst asserted with both stages valid -> out_valid=0, result=0 immediately (no clock edge); first post-reset input emerges after 2 cycles.
